mem_stage_stack: RTL and testbench

Memory-stage datapath block. It sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs: ALUResultM, WriteDataM, MemWriteM, PushM, PopM and MemSrcM. It contains the word-addressed data memory and the hardware stack pointer used by PUSH/POP instructions. ReadDataM is combinational and feeds the MEM/WB register in the same cycle. Stack fault conditions are reported as sticky status flags.

---
 rtl/mem_stage_stack.sv | 128 ++++++++++++
 tb/tb_mem_stage_stack.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_stack.sv
// Memory-stage datapath: word-addressed data memory plus a hardware
// stack pointer for PUSH/POP, with sticky stack fault flags.
module mem_stage_stack #(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 8,
   parameter int STACK_WORDS = 64
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   input  logic        PushM,
   input  logic        PopM,
   input  logic        MemSrcM,
   output logic [31:0] ReadDataM,
   output logic [31:0] SPM,
   output logic        StackEmpty,
   output logic        StackFull,
   output logic        StackOverflow,
   output logic        StackUnderflow,
   output logic        IllegalOp
);

   localparam int SPW = ADDR_W + 1;
   localparam logic [SPW-1:0] SP_TOP = SPW'(DEPTH);
   localparam logic [SPW-1:0] SP_LIM = SPW'(DEPTH - STACK_WORDS);
   localparam logic [SPW-1:0] SP_ONE = SPW'(1);

   logic [31:0]       mem_q [DEPTH];
   logic [SPW-1:0]    sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              ill_q, ill_d;
   logic              we;
   logic [ADDR_W-1:0] widx;
   logic [31:0]       rdata;
   logic [SPW-1:0]    sp_dec, sp_inc;
   logic [ADDR_W-1:0] dir_idx, top_idx, push_idx;
   logic              empty, full;
   logic              unused_bits;

   assign sp_dec   = sp_q - SP_ONE;
   assign sp_inc   = sp_q + SP_ONE;
   assign dir_idx  = ALUResultM[ADDR_W+1:2];
   assign top_idx  = sp_q[ADDR_W-1:0];
   assign push_idx = sp_dec[ADDR_W-1:0];
   assign empty    = (sp_q == SP_TOP);
   assign full     = (sp_q == SP_LIM);

   // Address bits outside the word index alias away by design.
   assign unused_bits = ^{ALUResultM[31:ADDR_W+2],
                          ALUResultM[1:0], sp_dec[ADDR_W]};

   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      ill_d = ill_q;
      we    = 1'b0;
      widx  = dir_idx;
      rdata = 32'h0;
      unique case (1'b1)
         (PushM && PopM): begin
            ill_d = 1'b1;
         end
         (PushM && !PopM): begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               we   = 1'b1;
               widx = push_idx;
               sp_d = sp_dec;
            end
         end
         (PopM && !PushM): begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               rdata = mem_q[top_idx];
               sp_d  = sp_inc;
            end
         end
         (!PushM && !PopM && !MemSrcM): begin
            rdata = mem_q[dir_idx];
            we    = MemWriteM;
         end
         (!PushM && !PopM && MemSrcM): begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               rdata = mem_q[top_idx];
               we    = MemWriteM;
               widx  = top_idx;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         sp_q  <= SP_TOP;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         ill_q <= ill_d;
      end
   end

   // Storage is never cleared; reset only suppresses the write.
   always_ff @(posedge CLK) begin
      if (!reset && we) mem_q[widx] <= WriteDataM;
   end

   assign ReadDataM      = rdata;
   assign SPM            = 32'({sp_q, 2'b00});
   assign StackEmpty     = empty;
   assign StackFull      = full;
   assign StackOverflow  = ovf_q;
   assign StackUnderflow = unf_q;
   assign IllegalOp      = ill_q;

endmodule

// File: tb/tb_mem_stage_stack.sv
// Bench for mem_stage_stack: scoreboarded reads plus
// stack pointer and sticky flag checks.
module tb_mem_stage_stack;

   logic        CLK = 1'b0;
   logic        reset;
   logic [31:0] ALUResultM, WriteDataM;
   logic        MemWriteM, PushM, PopM, MemSrcM;
   logic [31:0] ReadDataM, SPM;
   logic        StackEmpty, StackFull;
   logic        StackOverflow, StackUnderflow, IllegalOp;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd_seen;
   logic [31:0] e;

   always #5 CLK = ~CLK;

   mem_stage_stack dut (
      .CLK(CLK), .reset(reset),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .PushM(PushM), .PopM(PopM),
      .MemSrcM(MemSrcM), .ReadDataM(ReadDataM), .SPM(SPM),
      .StackEmpty(StackEmpty), .StackFull(StackFull),
      .StackOverflow(StackOverflow),
      .StackUnderflow(StackUnderflow), .IllegalOp(IllegalOp)
   );

   task automatic idle();
      PushM = 0; PopM = 0; MemSrcM = 0; MemWriteM = 0;
      ALUResultM = 0; WriteDataM = 0;
   endtask

   // One clock of stimulus; read data is sampled mid-cycle.
   task automatic op(input logic pu, po, src, wr,
                     input logic [31:0] a, wd,
                     input logic chk, input logic [31:0] ex);
      PushM = pu; PopM = po; MemSrcM = src; MemWriteM = wr;
      ALUResultM = a; WriteDataM = wd;
      if (chk) exp_q.push_back(ex);
      @(negedge CLK);
      rd_seen = ReadDataM;
      @(posedge CLK); #1;
      idle();
   endtask

   task automatic push(input logic [31:0] v);
      op(1, 0, 0, 0, 0, v, 0, 0);
   endtask
   task automatic pop(input logic [31:0] ex);
      op(0, 1, 0, 0, 0, 0, 1, ex);
   endtask
   task automatic load(input logic [31:0] a, ex);
      op(0, 0, 0, 0, a, 0, 1, ex);
   endtask
   task automatic store(input logic [31:0] a, v);
      op(0, 0, 0, 1, a, v, 0, 0);
   endtask

   task automatic do_reset(input logic pu);
      reset = 1; PushM = pu; WriteDataM = 32'h5555_5555;
      repeat (2) @(posedge CLK);
      #1;
      reset = 0;
      idle();
   endtask

   task automatic test_reset();
      do_reset(0);
      store(32'h3FC, 32'h1111_1111);
      do_reset(1);
      total++;
      if (SPM !== 32'h400) begin
         bad++; $display("FAIL rst_sp got=%h want=400", SPM);
      end
      total++;
      if ({StackEmpty, StackFull, StackOverflow,
           StackUnderflow, IllegalOp} !== 5'b10000) begin
         bad++;
         $display("FAIL rst_flags got=%b want=10000",
            {StackEmpty, StackFull, StackOverflow,
             StackUnderflow, IllegalOp});
      end
      load(32'h3FC, 32'h1111_1111);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL rst_nowrite got=%h want=%h", rd_seen, e);
      end
   endtask

   task automatic test_push_pop();
      push(32'hAAAA_0001);
      total++;
      if (SPM !== 32'h3FC) begin
         bad++; $display("FAIL push1_sp got=%h want=3fc", SPM);
      end
      push(32'hAAAA_0002);
      total++;
      if (SPM !== 32'h3F8) begin
         bad++; $display("FAIL push2_sp got=%h want=3f8", SPM);
      end
      load(32'h3F8, 32'hAAAA_0002);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL direct_top got=%h want=%h", rd_seen, e);
      end
      pop(32'hAAAA_0002);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL pop1 got=%h want=%h", rd_seen, e);
      end
      pop(32'hAAAA_0001);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL pop2 got=%h want=%h", rd_seen, e);
      end
      total++;
      if (SPM !== 32'h400 || StackEmpty !== 1'b1) begin
         bad++;
         $display("FAIL pp_end got=%h/%b want=400/1", SPM, StackEmpty);
      end
   endtask

   task automatic test_underflow();
      pop(32'h0);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e || SPM !== 32'h400) begin
         bad++;
         $display("FAIL unf_pop got=%h/%h want=%h/400", rd_seen, SPM, e);
      end
      total++;
      if (StackUnderflow !== 1'b1) begin
         bad++; $display("FAIL unf_set got=%b want=1", StackUnderflow);
      end
      push(32'h31); push(32'h32); push(32'h33);
      pop(32'h33);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL unf_pop3 got=%h want=%h", rd_seen, e);
      end
      pop(32'h32);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL unf_pop2 got=%h want=%h", rd_seen, e);
      end
      total++;
      if (StackUnderflow !== 1'b1 || SPM !== 32'h3FC) begin
         bad++;
         $display("FAIL unf_sticky got=%b/%h want=1/3fc",
            StackUnderflow, SPM);
      end
      do_reset(0);
      total++;
      if (StackUnderflow !== 1'b0) begin
         bad++; $display("FAIL unf_clear got=%b want=0", StackUnderflow);
      end
   endtask

   task automatic test_overflow();
      store(32'h2FC, 32'hCAFE_0000);
      for (int i = 0; i < 64; i++) push(32'(i));
      total++;
      if (StackFull !== 1'b1 || SPM !== 32'h300) begin
         bad++;
         $display("FAIL full got=%b/%h want=1/300", StackFull, SPM);
      end
      push(32'hDEAD_BEEF);
      total++;
      if (SPM !== 32'h300 || StackOverflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf got=%h/%b want=300/1", SPM, StackOverflow);
      end
      load(32'h2FC, 32'hCAFE_0000);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL ovf_nowrite got=%h want=%h", rd_seen, e);
      end
      op(0, 0, 1, 0, 0, 0, 1, 32'd63);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL ovf_top got=%h want=%h", rd_seen, e);
      end
      do_reset(0);
   endtask

   task automatic test_illegal();
      push(32'hB1); push(32'hB2); push(32'hB3);
      op(1, 1, 0, 1, 0, 32'hEE, 1, 32'h0);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e || SPM !== 32'h3F4) begin
         bad++;
         $display("FAIL ill got=%h/%h want=%h/3f4", rd_seen, SPM, e);
      end
      total++;
      if (IllegalOp !== 1'b1) begin
         bad++; $display("FAIL ill_flag got=%b want=1", IllegalOp);
      end
      pop(32'hB3);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL ill_pop got=%h want=%h", rd_seen, e);
      end
   endtask

   task automatic test_alias_peek();
      store(32'h10, 32'h1234_5678);
      load(32'h10, 32'h1234_5678);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL ld10 got=%h want=%h", rd_seen, e);
      end
      load(32'h413, 32'h1234_5678);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL ld413 got=%h want=%h", rd_seen, e);
      end
      op(0, 0, 1, 1, 0, 32'h77, 1, 32'hB2);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e || SPM !== 32'h3F8) begin
         bad++;
         $display("FAIL peekwr got=%h/%h want=%h/3f8", rd_seen, SPM, e);
      end
      pop(32'h77);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL peekpop got=%h want=%h", rd_seen, e);
      end
      pop(32'hB1);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL peekpop2 got=%h want=%h", rd_seen, e);
      end
   endtask

   task automatic test_peek_empty();
      do_reset(0);
      store(32'h3FC, 32'h4242_4242);
      op(0, 0, 1, 1, 0, 32'h99, 1, 32'h0);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e || StackUnderflow !== 1'b1) begin
         bad++;
         $display("FAIL peek_empty got=%h/%b want=%h/1",
            rd_seen, StackUnderflow, e);
      end
      load(32'h3FC, 32'h4242_4242);
      e = exp_q.pop_front(); total++;
      if (rd_seen !== e) begin
         bad++; $display("FAIL peek_drop got=%h want=%h", rd_seen, e);
      end
      do_reset(0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] model[$];
      logic [31:0] v;
      for (int i = 0; i < 60; i++) begin
         if (model.size() == 0 ||
             (model.size() < 64 && $urandom_range(0, 2) != 0)) begin
            v = $urandom;
            model.push_back(v);
            push(v);
         end else begin
            pop(model.pop_back());
            e = exp_q.pop_front(); total++;
            if (rd_seen !== e) begin
               bad++;
               $display("FAIL b2b_pop%0d got=%h want=%h", i, rd_seen, e);
            end
         end
         total++;
         if (SPM !== 32'h400 - 32'(4 * model.size())) begin
            bad++;
            $display("FAIL b2b_sp%0d got=%h want=%h", i, SPM,
               32'h400 - 32'(4 * model.size()));
         end
      end
   endtask

   initial begin
      reset = 1;
      idle();
      @(posedge CLK); #1;
      reset = 0;
      test_reset();
      test_push_pop();
      test_underflow();
      test_overflow();
      test_illegal();
      test_alias_peek();
      test_peek_empty();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
